calendar_counter: RTL and testbench

Sequential date counter generalising the combinational next-day logic to a full registered calendar. Holds day, month, year and weekday; advances one day per `advance` pulse with month lengths, leap years and year wrap derived internally rather than from an external month-type input. Supports synchronous load of an arbitrary date with validity checking. Sits behind a day-tick source (e.g. an RTC prescaler) and feeds display and timestamp logic.

---
 rtl/calendar_counter_if.sv | 31 +++
 rtl/calendar_counter.sv | 125 ++++++++++++
 tb/tb_calendar_counter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/calendar_counter_if.sv
// calendar_counter_if: groups the step/load request and date/pulse status signals of calendar_counter.
// The master drives requests and load values; the slave (the counter) returns date and event pulses.
interface calendar_counter_if #(
  parameter int YEAR_W = 12
);
  logic              advance;
  logic              load;
  logic [4:0]        ld_day;
  logic [3:0]        ld_month;
  logic [YEAR_W-1:0] ld_year;
  logic [2:0]        ld_weekday;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic [2:0]        weekday;
  logic              last_day;
  logic              month_tick;
  logic              year_tick;
  logic              year_wrap;
  logic              error;

  modport master (
    output advance, load, ld_day, ld_month, ld_year, ld_weekday,
    input  day, month, year, weekday, last_day, month_tick, year_tick, year_wrap, error
  );

  modport slave (
    input  advance, load, ld_day, ld_month, ld_year, ld_weekday,
    output day, month, year, weekday, last_day, month_tick, year_tick, year_wrap, error
  );
endinterface

// File: rtl/calendar_counter.sv
// calendar_counter: registered day/month/year/weekday calendar; define CAL_GREGORIAN_CENTURY_EN for century leap rule.
// Latency: advance/load sampled on a rising edge, new date and event pulses visible right after that edge.
// Backpressure: none; one step per cycle sustained, advance coinciding with load is dropped.
module calendar_counter #(
  parameter int YEAR_W        = 12,
  parameter int RESET_YEAR    = 2000,
  parameter int RESET_WEEKDAY = 6
) (
  input logic               clk,
  input logic               rst,
  calendar_counter_if.slave cal
);

  logic [4:0]        day_q,     day_d;
  logic [3:0]        month_q,   month_d;
  logic [YEAR_W-1:0] year_q,    year_d;
  logic [2:0]        weekday_q, weekday_d;
  logic              month_tick_q, month_tick_d;
  logic              year_tick_q,  year_tick_d;
  logic              year_wrap_q,  year_wrap_d;
  logic              error_q,      error_d;

  logic [4:0]        cur_len;
  logic [4:0]        ld_len;
  logic              last_day;
  logic              ld_ok;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] y32;
    y32 = 32'(y);
`ifdef CAL_GREGORIAN_CENTURY_EN
    is_leap = ((y32 % 32'd4) == 32'd0) &&
              (((y32 % 32'd100) != 32'd0) || ((y32 % 32'd400) == 32'd0));
`else
    is_leap = (y32 % 32'd4) == 32'd0;
`endif
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
      4'd2:                    month_len = leap ? 5'd29 : 5'd28;
      default:                 month_len = 5'd31;
    endcase
  endfunction

  // Month length of the registered date only, so last_day never sees the inputs.
  assign cur_len  = month_len(month_q, is_leap(year_q));
  assign last_day = (day_q == cur_len);

  assign ld_len = month_len(cal.ld_month, is_leap(cal.ld_year));
  assign ld_ok  = (cal.ld_month >= 4'd1) && (cal.ld_month <= 4'd12) &&
                  (cal.ld_day >= 5'd1) && (cal.ld_day <= ld_len) &&
                  (cal.ld_weekday <= 3'd6);

  always_comb begin
    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    weekday_d    = weekday_q;
    month_tick_d = 1'b0;
    year_tick_d  = 1'b0;
    year_wrap_d  = 1'b0;
    error_d      = 1'b0;
    if (cal.load) begin
      if (ld_ok) begin
        day_d     = cal.ld_day;
        month_d   = cal.ld_month;
        year_d    = cal.ld_year;
        weekday_d = cal.ld_weekday;
      end else begin
        error_d = 1'b1;
      end
    end else if (cal.advance) begin
      weekday_d = (weekday_q == 3'd6) ? 3'd0 : weekday_q + 3'd1;
      if (!last_day) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d        = 5'd1;
        month_tick_d = 1'b1;
        if (month_q == 4'd12) begin
          month_d     = 4'd1;
          year_d      = year_q + YEAR_W'(1);
          year_tick_d = 1'b1;
          year_wrap_d = &year_q;
        end else begin
          month_d = month_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q        <= 5'd1;
      month_q      <= 4'd1;
      year_q       <= YEAR_W'(RESET_YEAR);
      weekday_q    <= 3'(RESET_WEEKDAY);
      month_tick_q <= 1'b0;
      year_tick_q  <= 1'b0;
      year_wrap_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      weekday_q    <= weekday_d;
      month_tick_q <= month_tick_d;
      year_tick_q  <= year_tick_d;
      year_wrap_q  <= year_wrap_d;
      error_q      <= error_d;
    end
  end

  assign cal.day        = day_q;
  assign cal.month      = month_q;
  assign cal.year       = year_q;
  assign cal.weekday    = weekday_q;
  assign cal.last_day   = last_day;
  assign cal.month_tick = month_tick_q;
  assign cal.year_tick  = year_tick_q;
  assign cal.year_wrap  = year_wrap_q;
  assign cal.error      = error_q;

endmodule

// File: tb/tb_calendar_counter.sv
// tb_calendar_counter: directed vectors for calendar_counter with hand-computed expected dates and pulses.
// Pulses are compared as {month_tick, year_tick, year_wrap, error}.
module tb_calendar_counter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  calendar_counter_if #(.YEAR_W(12)) cal ();

  calendar_counter #(
    .YEAR_W(12),
    .RESET_YEAR(2000),
    .RESET_WEEKDAY(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cal(cal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_date(input string tag, input int d, input int m, input int y, input int w);
    check({tag, ".day"},     32'(cal.day),     32'(d));
    check({tag, ".month"},   32'(cal.month),   32'(m));
    check({tag, ".year"},    32'(cal.year),    32'(y));
    check({tag, ".weekday"}, 32'(cal.weekday), 32'(w));
  endtask

  task automatic chk_pulses(input string tag, input logic [3:0] exp);
    check({tag, ".pulses"},
          32'({cal.month_tick, cal.year_tick, cal.year_wrap, cal.error}), 32'(exp));
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input int d, input int m, input int y, input int w);
    cal.ld_day     = 5'(d);
    cal.ld_month   = 4'(m);
    cal.ld_year    = 12'(y);
    cal.ld_weekday = 3'(w);
  endtask

  task automatic do_load(input int d, input int m, input int y, input int w);
    set_ld(d, m, y, w);
    cal.load = 1'b1;
    tick();
    cal.load = 1'b0;
  endtask

  task automatic do_adv();
    cal.advance = 1'b1;
    tick();
    cal.advance = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    cal.advance = 1'b0;
    cal.load    = 1'b0;
    set_ld(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state.
    chk_date("reset", 1, 1, 2000, 6);
    check("reset.last_day", 32'(cal.last_day), 32'd0);
    chk_pulses("reset", 4'b0000);

    // Leap February 2000 and month crossing.
    do_load(28, 2, 2000, 1);
    chk_date("ld_feb28", 28, 2, 2000, 1);
    check("ld_feb28.last_day", 32'(cal.last_day), 32'd0);
    chk_pulses("ld_feb28", 4'b0000);
    do_adv();
    chk_date("feb29", 29, 2, 2000, 2);
    check("feb29.last_day", 32'(cal.last_day), 32'd1);
    chk_pulses("feb29", 4'b0000);
    do_adv();
    chk_date("mar1", 1, 3, 2000, 3);
    chk_pulses("mar1", 4'b1000);
    tick();
    chk_pulses("mar1_idle", 4'b0000);

    // Century year 1900.
    do_load(28, 2, 1900, 3);
    do_adv();
`ifdef CAL_GREGORIAN_CENTURY_EN
    chk_date("y1900", 1, 3, 1900, 4);
    chk_pulses("y1900", 4'b1000);
`else
    chk_date("y1900", 29, 2, 1900, 4);
    chk_pulses("y1900", 4'b0000);
`endif

    // Year crossing and year wrap.
    do_load(31, 12, 2023, 0);
    check("dec31.last_day", 32'(cal.last_day), 32'd1);
    do_adv();
    chk_date("ny2024", 1, 1, 2024, 1);
    chk_pulses("ny2024", 4'b1100);
    do_load(31, 12, 4095, 6);
    do_adv();
    chk_date("wrap", 1, 1, 0, 0);
    chk_pulses("wrap", 4'b1110);
    tick();
    chk_pulses("wrap_idle", 4'b0000);

    // Load validity: rejected loads leave state untouched.
    do_load(15, 6, 2023, 4);
    chk_date("ld_jun15", 15, 6, 2023, 4);
    do_load(31, 4, 2023, 2);
    chk_date("bad_apr31", 15, 6, 2023, 4);
    chk_pulses("bad_apr31", 4'b0001);
    tick();
    chk_pulses("bad_apr31_idle", 4'b0000);
    do_load(1, 13, 2023, 2);
    chk_date("bad_m13", 15, 6, 2023, 4);
    chk_pulses("bad_m13", 4'b0001);
    do_load(1, 5, 2023, 7);
    chk_date("bad_wd7", 15, 6, 2023, 4);
    chk_pulses("bad_wd7", 4'b0001);
    do_load(0, 5, 2023, 1);
    chk_pulses("bad_d0", 4'b0001);
    do_load(1, 0, 2023, 1);
    chk_pulses("bad_m0", 4'b0001);
    do_load(29, 2, 2023, 3);
    chk_date("bad_feb29_2023", 15, 6, 2023, 4);
    chk_pulses("bad_feb29_2023", 4'b0001);
    do_load(29, 2, 2024, 4);
    chk_date("ok_feb29_2024", 29, 2, 2024, 4);
    chk_pulses("ok_feb29_2024", 4'b0000);
    check("ok_feb29_2024.last_day", 32'(cal.last_day), 32'd1);
    do_load(30, 9, 2023, 6);
    chk_date("ok_sep30", 30, 9, 2023, 6);
    check("ok_sep30.last_day", 32'(cal.last_day), 32'd1);

    // Load wins over advance in the same cycle.
    set_ld(15, 6, 2023, 4);
    cal.load    = 1'b1;
    cal.advance = 1'b1;
    tick();
    cal.load    = 1'b0;
    cal.advance = 1'b0;
    chk_date("ld_and_adv", 15, 6, 2023, 4);
    chk_pulses("ld_and_adv", 4'b0000);

    // Back-to-back advance, one day per cycle.
    do_load(30, 1, 2023, 1);
    cal.advance = 1'b1;
    tick();
    chk_date("b2b_1", 31, 1, 2023, 2);
    chk_pulses("b2b_1", 4'b0000);
    tick();
    chk_date("b2b_2", 1, 2, 2023, 3);
    chk_pulses("b2b_2", 4'b1000);
    tick();
    chk_date("b2b_3", 2, 2, 2023, 4);
    chk_pulses("b2b_3", 4'b0000);
    cal.advance = 1'b0;

    // Reset together with load and advance.
    set_ld(15, 6, 2023, 4);
    rst         = 1'b1;
    cal.load    = 1'b1;
    cal.advance = 1'b1;
    tick();
    rst         = 1'b0;
    cal.load    = 1'b0;
    cal.advance = 1'b0;
    chk_date("rst_ld", 1, 1, 2000, 6);
    chk_pulses("rst_ld", 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
